xadac_ex_arbiter: RTL and testbench
===================================

Name: xadac_ex_arbiter

Overview:
- Shares one xadac execution unit (e.g. the vector-bias unit) between NumReq requester ports.
- Fair round-robin arbitration on the request channel.
- Each response returns to the requester that issued it, in issue order, via an in-order tag FIFO.
- Supports downstream units with same-cycle (combinational) response and units with multi-cycle latency.

Parameters:
- NumReq, 2, number of requester ports (2..8)
- IdWidth, 4, width of req_id/resp_id
- XWidth, 32, scalar operand width (rs1, rd)
- VWidth, 256, vector result width (vd)
- ImmWidth, 5, immediate width
- MaxOut, 4, max accepted-but-unanswered requests (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m_req_valid  in  NumReq  per-requester request valid
- m_req_ready  out  NumReq  per-requester request ready
- m_req_id  in  NumReq*IdWidth  request id
- m_req_rs1  in  NumReq*XWidth  scalar operand
- m_req_imm  in  NumReq*ImmWidth  immediate
- m_resp_valid  out  NumReq  response valid
- m_resp_ready  in  NumReq  response ready
- m_resp_id  out  NumReq*IdWidth  response id (broadcast)
- m_resp_rd  out  NumReq*XWidth  scalar result (broadcast)
- m_resp_vd  out  NumReq*VWidth  vector result (broadcast)
- s_req_valid  out  1  request to unit
- s_req_ready  in  1  unit accepts
- s_req_id / s_req_rs1 / s_req_imm  out  IdWidth / XWidth / ImmWidth  muxed payload
- s_resp_valid  in  1  unit response valid
- s_resp_ready  out  1  response accepted
- s_resp_id / s_resp_rd / s_resp_vd  in  IdWidth / XWidth / VWidth  unit response

Behaviour:
- Reset (rst=1 at clk edge): round-robin pointer=0, lock=0, tag FIFO empty (rd/wr ptr=0, count=0). While rst is high, all outputs valid/ready=0.
- Arbitration:
  - Candidates are requesters with m_req_valid=1.
  - Winner is the first candidate at index >= ptr, wrapping modulo NumReq.
  - Grant is issued only when count<MaxOut.
  - Full (count==MaxOut): s_req_valid=0 and all m_req_ready=0, even if a pop occurs the same cycle.
- Lock: if s_req_valid=1 and s_req_ready=0, latch lock=1 and hold the same grant index until the handshake, so AXI-style valid stability holds downstream.
- Request path: s_req_* = payload of the winner. m_req_ready[w] = s_req_ready & grant; all other m_req_ready are 0.
- Request accept (s_req_valid & s_req_ready):
  - Push the winner index into the tag FIFO.
  - ptr <= (w+1) mod NumReq.
  - lock <= 0.
- Response routing:
  - dest = FIFO head if count>0.
  - If count==0 and a request is accepted the same cycle, dest = current winner (bypass). This supports zero-latency units.
  - m_resp_valid[dest] = s_resp_valid; all other m_resp_valid are 0.
  - s_resp_ready = m_resp_ready[dest].
  - If count==0 and no accept is in progress, s_resp_ready=0 and all m_resp_valid=0. A stray response is never forwarded.
- Response accept (s_resp_valid & s_resp_ready): pop the FIFO, or consume the bypass entry.
- Bypass case: a same-cycle push and pop leave count unchanged and the pointers unchanged.
- Simultaneous push and pop with count>0: write and read both occur; count unchanged; pointers wrap modulo MaxOut.
- Width rules:
  - Payloads pass through unmodified.
  - FIFO entry width = clog2(NumReq), minimum 1.
  - count width = clog2(MaxOut)+1.
- Latency: request path is combinational (0 cycles); response path is combinational from s_resp_* to m_resp_*. The block adds no bubbles.
- Reset mid-operation: all outstanding tags are discarded. Downstream is reset by the same rst, so no late responses are routed.
- Assertions:
  - No push when full.
  - No pop when empty without bypass.
  - s_req payload stable while s_req_valid & !s_req_ready.

Test Plan:
- Reset then single requester: m_req_valid[1]=1, id=3, rs1=0x5, zero-latency unit → same cycle: s_req_id=3, m_resp_valid=2'b10, resp_id=3; count stays 0.
- Both valid continuously, always-ready unit → grants alternate 0,1,0,1 over 4 cycles; each response is delivered only to its issuer.
- Unit with 3-cycle latency, requester 0 issues 4 back-to-back → count reaches 4. A 5th request (either port) sees m_req_ready=0 until the first response pops.
- s_req_ready held 0 for 2 cycles with both valid, ptr=0 → grant stays on 0 (locked) despite requester 1 valid. Requester 1 is granted the cycle after the accept.
- m_resp_ready[dest]=0 for 3 cycles → s_resp_ready=0 and the FIFO head is unchanged. On release, the pop occurs and the next response routes to the next tag.
- rst asserted with count=3 → next cycle count=0, all valids/readies=0. A subsequent request is routed correctly from ptr=0.

Source files
------------

// File: rtl/xadac_ex_arbiter.sv
// -----------------------------------------------------------------------------
// xadac_ex_arbiter
//
// Shares one xadac execution unit between NumReq requester ports. Requests are
// arbitrated round-robin; each accepted request pushes its requester index
// into an in-order tag FIFO so the matching response (the unit answers in
// issue order) is routed back to the requester that issued it. A unit that
// answers in the same cycle as the request is served through a bypass of the
// empty FIFO.
//
// Handshake rule on every channel: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. A valid that is raised
// must stay high, with its payload unchanged, until the transfer happens.
// Ready may depend combinationally on valid.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m_req_valid/ready        per-requester request handshake
//   m_req_id/rs1/imm         per-requester request payload (flattened)
//   m_resp_valid/ready       per-requester response handshake
//   m_resp_id/rd/vd          response payload, broadcast to every requester
//   s_req_valid/ready        request handshake towards the unit
//   s_req_id/rs1/imm         payload of the granted requester
//   s_resp_valid/ready       response handshake from the unit
//   s_resp_id/rd/vd          unit response payload
//   o_dbg_locked             arbiter FSM state (1 = grant held for a stalled request)
// -----------------------------------------------------------------------------
module xadac_ex_arbiter #(
    parameter int NumReq   = 2,
    parameter int IdWidth  = 4,
    parameter int XWidth   = 32,
    parameter int VWidth   = 256,
    parameter int ImmWidth = 5,
    parameter int MaxOut   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NumReq-1:0]            m_req_valid,
    output logic [NumReq-1:0]            m_req_ready,
    input  logic [NumReq*IdWidth-1:0]    m_req_id,
    input  logic [NumReq*XWidth-1:0]     m_req_rs1,
    input  logic [NumReq*ImmWidth-1:0]   m_req_imm,
    output logic [NumReq-1:0]            m_resp_valid,
    input  logic [NumReq-1:0]            m_resp_ready,
    output logic [NumReq*IdWidth-1:0]    m_resp_id,
    output logic [NumReq*XWidth-1:0]     m_resp_rd,
    output logic [NumReq*VWidth-1:0]     m_resp_vd,
    output logic                         s_req_valid,
    input  logic                         s_req_ready,
    output logic [IdWidth-1:0]           s_req_id,
    output logic [XWidth-1:0]            s_req_rs1,
    output logic [ImmWidth-1:0]          s_req_imm,
    input  logic                         s_resp_valid,
    output logic                         s_resp_ready,
    input  logic [IdWidth-1:0]           s_resp_id,
    input  logic [XWidth-1:0]            s_resp_rd,
    input  logic [VWidth-1:0]            s_resp_vd,
    output logic                         o_dbg_locked
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PtrW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
    localparam int CntW = $clog2(MaxOut) + 1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [IdxW-1:0]       r_ptr;
    logic [IdxW-1:0]       r_lock_idx;
    logic [IdxW-1:0]       r_fifo [MaxOut];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic                  w_rr_found;
    logic [IdxW-1:0]       w_rr_idx;
    logic                  w_locked;
    logic [IdxW-1:0]       w_grant_idx;
    logic                  w_grant_any;
    logic                  w_full;
    logic                  w_s_req_valid;
    logic                  w_req_acc;
    logic [IdxW-1:0]       w_ptr_nxt;
    logic                  w_fifo_nonempty;
    logic [IdxW-1:0]       w_head;
    logic                  w_bypass;
    logic                  w_dest_vld;
    logic [IdxW-1:0]       w_dest;
    logic                  w_s_resp_ready;
    logic                  w_resp_acc;
    logic                  w_push;
    logic                  w_pop;

    // First requester with valid set at or after ptr, wrapping modulo NumReq.
    // Returns {found, index}.
    function automatic logic [IdxW:0] f_rr_pick(input logic [NumReq-1:0] valid,
                                                input logic [IdxW-1:0]   ptr);
        logic            found;
        logic [IdxW-1:0] idx;
        int              j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            j = int'(ptr) + i;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            if (!found && valid[j]) begin
                found = 1'b1;
                idx   = IdxW'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin : p_rr
        {w_rr_found, w_rr_idx} = f_rr_pick(m_req_valid, r_ptr);
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM: OPEN picks a fresh round-robin winner every cycle; LOCKED
    // holds the previous winner while its request waits for s_req_ready, so
    // the downstream request stays stable.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            r_state <= ARB_OPEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            ARB_OPEN: begin
                if (w_s_req_valid && !s_req_ready) begin
                    w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // Release on the handshake, or if the held request vanished.
                if (w_req_acc || !w_s_req_valid) begin
                    w_state_nxt = ARB_OPEN;
                end
            end
            default: w_state_nxt = ARB_OPEN;
        endcase
    end

    always_comb begin : p_fsm_out
        w_locked     = (r_state == ARB_LOCKED);
        w_grant_idx  = w_locked ? r_lock_idx : w_rr_idx;
        w_grant_any  = w_locked ? m_req_valid[r_lock_idx] : w_rr_found;
        o_dbg_locked = w_locked;
    end

    // -------------------------------------------------------------------------
    // Request path
    // -------------------------------------------------------------------------
    always_comb begin : p_req_path
        // A full tag FIFO blocks new grants even if a pop happens this cycle.
        w_full        = (r_count == CntW'(MaxOut));
        w_s_req_valid = !rst && w_grant_any && !w_full;
        w_req_acc     = w_s_req_valid && s_req_ready;
        s_req_valid   = w_s_req_valid;
        s_req_id      = m_req_id[w_grant_idx*IdWidth +: IdWidth];
        s_req_rs1     = m_req_rs1[w_grant_idx*XWidth +: XWidth];
        s_req_imm     = m_req_imm[w_grant_idx*ImmWidth +: ImmWidth];
        m_req_ready   = '0;
        for (int k = 0; k < NumReq; k++) begin
            m_req_ready[k] = w_req_acc && (w_grant_idx == IdxW'(k));
        end
        w_ptr_nxt = (w_grant_idx == IdxW'(NumReq - 1)) ? '0 : w_grant_idx + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Response path
    // -------------------------------------------------------------------------
    always_comb begin : p_resp_path
        w_fifo_nonempty = (r_count != '0);
        w_head          = r_fifo[r_rd_ptr];
        // Empty FIFO plus a request accepted now: a zero-latency unit may
        // answer in this same cycle, so route to the current winner.
        w_bypass        = !w_fifo_nonempty && w_req_acc;
        w_dest_vld      = !rst && (w_fifo_nonempty || w_bypass);
        w_dest          = w_fifo_nonempty ? w_head : w_grant_idx;
        w_s_resp_ready  = w_dest_vld && m_resp_ready[w_dest];
        w_resp_acc      = s_resp_valid && w_s_resp_ready;
        s_resp_ready    = w_s_resp_ready;
        m_resp_valid    = '0;
        for (int k = 0; k < NumReq; k++) begin
            m_resp_valid[k] = w_dest_vld && s_resp_valid && (w_dest == IdxW'(k));
        end
        m_resp_id = {NumReq{s_resp_id}};
        m_resp_rd = {NumReq{s_resp_rd}};
        m_resp_vd = {NumReq{s_resp_vd}};
        // A bypass that completes in the same cycle never touches the FIFO.
        w_push = w_req_acc && !(w_bypass && w_resp_acc);
        w_pop  = w_resp_acc && w_fifo_nonempty;
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer and lock index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_arb_regs
        if (rst) begin
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            if (w_req_acc) begin
                r_ptr <= w_ptr_nxt;
            end
            if (!w_locked) begin
                r_lock_idx <= w_rr_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_fifo_ctrl
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin : p_fifo_mem
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_grant_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full));

    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(w_resp_acc && !w_fifo_nonempty && !w_bypass));

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (s_req_valid && !s_req_ready) |=>
            (s_req_valid && $stable(s_req_id) && $stable(s_req_rs1) && $stable(s_req_imm)));
`endif

endmodule

// File: tb/tb_xadac_ex_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xadac_ex_arbiter
//
// Per cycle (period 10, posedge at +0):
//   +1 main sequence changes knobs / reset
//   +2 requesters, s_req_ready and m_resp_ready are driven
//   +3 behavioural execution unit drives its response
//   +5 (negedge) reference model checks outputs and advances; unit bookkeeping
//   +6 response monitor pops the expected queue and compares
// -----------------------------------------------------------------------------
module tb_xadac_ex_arbiter;

    localparam int N  = 2;
    localparam int IW = 4;
    localparam int XW = 32;
    localparam int VW = 256;
    localparam int MW = 5;
    localparam int MO = 4;
    localparam int EW = 8 + IW + XW + MW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [N-1:0]    m_req_valid;
    logic [N-1:0]    m_req_ready;
    logic [N*IW-1:0] m_req_id;
    logic [N*XW-1:0] m_req_rs1;
    logic [N*MW-1:0] m_req_imm;
    logic [N-1:0]    m_resp_valid;
    logic [N-1:0]    m_resp_ready;
    logic [N*IW-1:0] m_resp_id;
    logic [N*XW-1:0] m_resp_rd;
    logic [N*VW-1:0] m_resp_vd;
    logic            s_req_valid;
    logic            s_req_ready;
    logic [IW-1:0]   s_req_id;
    logic [XW-1:0]   s_req_rs1;
    logic [MW-1:0]   s_req_imm;
    logic            s_resp_valid;
    logic            s_resp_ready;
    logic [IW-1:0]   s_resp_id;
    logic [XW-1:0]   s_resp_rd;
    logic [VW-1:0]   s_resp_vd;
    logic            o_dbg_locked;

    xadac_ex_arbiter #(
        .NumReq(N), .IdWidth(IW), .XWidth(XW), .VWidth(VW), .ImmWidth(MW), .MaxOut(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_id(m_req_id), .m_req_rs1(m_req_rs1), .m_req_imm(m_req_imm),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_id(m_resp_id), .m_resp_rd(m_resp_rd), .m_resp_vd(m_resp_vd),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_id(s_req_id), .s_req_rs1(s_req_rs1), .s_req_imm(s_req_imm),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_id(s_resp_id), .s_resp_rd(s_resp_rd), .s_resp_vd(s_resp_vd),
        .o_dbg_locked(o_dbg_locked)
    );

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int p_req [N];
    int p_sready;
    int p_rready;
    int unit_lat;
    bit dir_pend [N];

    logic          q_valid [N];
    logic [IW-1:0] q_id    [N];
    logic [XW-1:0] q_rs1   [N];
    logic [MW-1:0] q_imm   [N];
    logic [N-1:0]  acc_seen;

    typedef struct {
        int            due;
        logic [IW-1:0] id;
        logic [XW-1:0] rd;
        logic [VW-1:0] vd;
    } unit_ent_t;
    unit_ent_t unit_q[$];

    // reference model
    int            tag_q[$];
    int            md_ptr;
    bit            md_lock;
    int            md_lock_idx;
    logic [EW-1:0] exp_q[$];

    // execution-unit function
    function automatic logic [XW-1:0] f_rd(input logic [XW-1:0] rs1, input logic [MW-1:0] imm);
        return (rs1 + XW'(imm)) ^ 32'h0000_0101;
    endfunction

    function automatic logic [VW-1:0] f_vd(input logic [XW-1:0] rs1, input logic [MW-1:0] imm);
        logic [VW-1:0] v;
        for (int i = 0; i < VW / XW; i++) begin
            v[i*XW +: XW] = rs1 + XW'(i) + XW'(imm);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- driver (+2) and execution unit (+3) ----------------
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                q_valid[k] = 1'b0;
            end else if (!q_valid[k] || acc_seen[k]) begin
                q_valid[k] = ($urandom_range(0, 99) < p_req[k]);
                if (q_valid[k] && dir_pend[k]) begin
                    q_id[k]     = 4'd3;
                    q_rs1[k]    = 32'h5;
                    q_imm[k]    = '0;
                    dir_pend[k] = 1'b0;
                end else begin
                    q_id[k]  = IW'($urandom_range(0, 15));
                    q_rs1[k] = $urandom;
                    q_imm[k] = MW'($urandom_range(0, 31));
                end
            end
            m_req_valid[k]          = q_valid[k];
            m_req_id[k*IW +: IW]    = q_id[k];
            m_req_rs1[k*XW +: XW]   = q_rs1[k];
            m_req_imm[k*MW +: MW]   = q_imm[k];
            m_resp_ready[k]         = ($urandom_range(0, 99) < p_rready);
        end
        s_req_ready = ($urandom_range(0, 99) < p_sready);
        #1;
        if (unit_q.size() > 0 && unit_q[0].due <= cyc) begin
            s_resp_valid = 1'b1;
            s_resp_id    = unit_q[0].id;
            s_resp_rd    = unit_q[0].rd;
            s_resp_vd    = unit_q[0].vd;
        end else if (unit_lat == 0 && unit_q.size() == 0 && s_req_valid && s_req_ready) begin
            s_resp_valid = 1'b1;
            s_resp_id    = s_req_id;
            s_resp_rd    = f_rd(s_req_rs1, s_req_imm);
            s_resp_vd    = f_vd(s_req_rs1, s_req_imm);
        end else begin
            s_resp_valid = 1'b0;
            s_resp_id    = '0;
            s_resp_rd    = '0;
            s_resp_vd    = '0;
        end
    end

    // ---------------- execution-unit bookkeeping (negedge) ----------------
    always @(negedge clk) begin
        unit_ent_t ue;
        if (rst) begin
            unit_q.delete();
            acc_seen = '0;
        end else begin
            acc_seen = m_req_valid & m_req_ready;
            if (s_req_valid && s_req_ready) begin
                ue.due = cyc + unit_lat;
                ue.id  = s_req_id;
                ue.rd  = f_rd(s_req_rs1, s_req_imm);
                ue.vd  = f_vd(s_req_rs1, s_req_imm);
                unit_q.push_back(ue);
            end
            if (s_resp_valid && s_resp_ready && unit_q.size() > 0) begin
                void'(unit_q.pop_front());
            end
        end
        cyc++;
    end

    // ---------------- reference model and per-cycle checks (negedge) ----------------
    int           md_w;
    bit           md_found;
    bit           e_sv;
    bit           e_acc;
    int           e_dest;
    logic [N-1:0] e_mr;
    logic [N-1:0] e_rv;
    bit           e_srr;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_s_req_valid",  VW'(s_req_valid),  '0);
            chk("rst_m_req_ready",  VW'(m_req_ready),  '0);
            chk("rst_m_resp_valid", VW'(m_resp_valid), '0);
            chk("rst_s_resp_ready", VW'(s_resp_ready), '0);
            tag_q.delete();
            exp_q.delete();
            md_ptr  = 0;
            md_lock = 1'b0;
        end else begin
            md_found = 1'b0;
            md_w     = 0;
            if (md_lock) begin
                md_w     = md_lock_idx;
                md_found = q_valid[md_w];
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!md_found && q_valid[(md_ptr + i) % N]) begin
                        md_found = 1'b1;
                        md_w     = (md_ptr + i) % N;
                    end
                end
            end
            e_sv  = md_found && (tag_q.size() < MO);
            e_acc = e_sv && s_req_ready;
            e_mr  = e_acc ? N'(1 << md_w) : '0;
            if (tag_q.size() > 0)  e_dest = tag_q[0];
            else if (e_acc)        e_dest = md_w;
            else                   e_dest = -1;
            e_rv  = (e_dest >= 0 && s_resp_valid) ? N'(1 << e_dest) : '0;
            e_srr = (e_dest >= 0) ? m_resp_ready[e_dest] : 1'b0;

            chk("s_req_valid",  VW'(s_req_valid),  VW'(e_sv));
            chk("m_req_ready",  VW'(m_req_ready),  VW'(e_mr));
            chk("m_resp_valid", VW'(m_resp_valid), VW'(e_rv));
            chk("s_resp_ready", VW'(s_resp_ready), VW'(e_srr));
            chk("dbg_locked",   VW'(o_dbg_locked), VW'(md_lock));
            chk("m_resp_id_bcast", VW'(m_resp_id), VW'({N{s_resp_id}}));
            if (e_sv) begin
                chk("s_req_id",  VW'(s_req_id),  VW'(q_id[md_w]));
                chk("s_req_rs1", VW'(s_req_rs1), VW'(q_rs1[md_w]));
                chk("s_req_imm", VW'(s_req_imm), VW'(q_imm[md_w]));
            end

            if (e_acc) begin
                tag_q.push_back(md_w);
                exp_q.push_back({8'(md_w), q_id[md_w], q_rs1[md_w], q_imm[md_w]});
                md_ptr  = (md_w + 1) % N;
                md_lock = 1'b0;
            end else begin
                md_lock     = e_sv;
                md_lock_idx = md_w;
            end
            if (s_resp_valid && e_srr) begin
                void'(tag_q.pop_front());
            end
        end
    end

    // ---------------- response monitor (negedge + 1) ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (m_resp_valid[k] && m_resp_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL resp_unexpected at cycle %0d: requester %0d got a response, none expected", cyc, k);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_dest", VW'(k), VW'(e[EW-1 -: 8]));
                        chk("resp_id", VW'(m_resp_id[k*IW +: IW]), VW'(e[IW+XW+MW-1 -: IW]));
                        chk("resp_rd", VW'(m_resp_rd[k*XW +: XW]),
                            VW'(f_rd(e[XW+MW-1 -: XW], e[MW-1:0])));
                        chk("resp_vd", m_resp_vd[k*VW +: VW], f_vd(e[XW+MW-1 -: XW], e[MW-1:0]));
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic set_req(input int p0, input int p1);
        p_req[0] = p0;
        p_req[1] = p1;
    endtask

    initial begin
        rst          = 1'b1;
        m_req_valid  = '0;
        m_req_id     = '0;
        m_req_rs1    = '0;
        m_req_imm    = '0;
        m_resp_ready = '0;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        s_resp_id    = '0;
        s_resp_rd    = '0;
        s_resp_vd    = '0;
        acc_seen     = '0;
        md_ptr       = 0;
        md_lock      = 1'b0;
        md_lock_idx  = 0;
        for (int k = 0; k < N; k++) begin
            q_valid[k]  = 1'b0;
            q_id[k]     = '0;
            q_rs1[k]    = '0;
            q_imm[k]    = '0;
            dir_pend[k] = 1'b0;
        end
        set_req(0, 0);
        p_sready = 100;
        p_rready = 100;
        unit_lat = 0;

        cycles(3);
        rst = 1'b0;

        // single requester 1, zero-latency unit, same-cycle response
        set_req(0, 100);
        dir_pend[1] = 1'b1;
        @(negedge clk);
        #2;
        chk("dir_s_req_valid", VW'(s_req_valid), VW'(1'b1));
        chk("dir_s_req_id", VW'(s_req_id), VW'(4'd3));
        chk("dir_s_req_rs1", VW'(s_req_rs1), VW'(32'h5));
        chk("dir_m_resp_valid", VW'(m_resp_valid), VW'(2'b10));
        chk("dir_m_resp_id", VW'(m_resp_id[IW +: IW]), VW'(4'd3));
        chk("dir_m_resp_rd", VW'(m_resp_rd[XW +: XW]), VW'(f_rd(32'h5, 5'd0)));
        cycles(6);

        // both requesters continuously valid, always-ready unit
        set_req(100, 100);
        cycles(8);
        unit_lat = 1;
        cycles(8);

        // 3-cycle unit, requester 0 back-to-back, responses held off to fill
        set_req(0, 0);
        cycles(8);
        unit_lat = 3;
        p_rready = 0;
        set_req(100, 0);
        cycles(6);
        set_req(100, 100);
        cycles(3);
        p_rready = 100;
        cycles(15);

        // lock: s_req_ready low 2 cycles with both valid, ptr at 0
        set_req(0, 0);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        unit_lat = 0;
        p_sready = 0;
        set_req(100, 100);
        cycles(2);
        p_sready = 100;
        cycles(6);

        // response back-pressure for 3 cycles
        unit_lat = 1;
        p_rready = 0;
        cycles(3);
        p_rready = 100;
        cycles(8);

        // reset with outstanding tags
        set_req(0, 0);
        cycles(8);
        unit_lat = 8;
        p_rready = 0;
        set_req(100, 0);
        cycles(3);
        set_req(0, 0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        unit_lat = 0;
        p_rready = 100;
        set_req(0, 100);
        cycles(6);

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            unit_lat = $urandom_range(0, 3);
            set_req($urandom_range(10, 100), $urandom_range(10, 100));
            p_sready = $urandom_range(30, 100);
            p_rready = $urandom_range(30, 100);
            if (r == 20) begin
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end
            cycles(50);
        end

        // drain
        set_req(0, 0);
        p_sready = 100;
        p_rready = 100;
        unit_lat = 0;
        cycles(30);
        chk("exp_q_drained", VW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
